// File: rtl/prt_dp_pm_hpd_pkg.sv
// ============================================================================
// Module      : prt_dp_pm_hpd_pkg
// Description : Shared definitions for the DP HPD peripheral controller:
//               register addresses, control/status bit positions, event
//               codes, the controller state enum and a clear-word helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prt_dp_pm_hpd_pkg;

  // Local bus register map of the HPD peripheral
  localparam logic [1:0] ADR_CTRL = 2'd0;
  localparam logic [1:0] ADR_STAT = 2'd1;

  // Control register bits
  localparam int CTRL_RUN_BIT = 0;
  localparam int CTRL_IE_BIT  = 1;

  // Status register bits (event bits are write-one-to-clear)
  localparam int STAT_CLR_BIT    = 0;
  localparam int STAT_HPD_BIT    = 1;
  localparam int STAT_UNPLUG_BIT = 2;
  localparam int STAT_PLUG_BIT   = 3;
  localparam int STAT_PULSE_BIT  = 4;

  // Control word that starts the peripheral with its interrupt enabled
  localparam logic [31:0] CTRL_START = (32'd1 << CTRL_RUN_BIT) | (32'd1 << CTRL_IE_BIT);

  // Event codes delivered on the event stream
  localparam logic [1:0] EVT_UNPLUG = 2'd1;
  localparam logic [1:0] EVT_PLUG   = 2'd2;
  localparam logic [1:0] EVT_PULSE  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INIT     = 3'd1,
    S_WAIT_IRQ = 3'd2,
    S_RD       = 3'd3,
    S_WAIT_VLD = 3'd4,
    S_PUSH     = 3'd5,
    S_CLR      = 3'd6,
    S_STOP     = 3'd7
  } state_e;

  // Status clear word: acknowledge exactly the observed event bits
  function automatic logic [31:0] clr_word(input logic [2:0] evt);
    logic [31:0] w;
    w = '0;
    w[STAT_PULSE_BIT:STAT_UNPLUG_BIT] = evt;
    w[STAT_CLR_BIT] = 1'b1;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prt_dp_pm_hpd_ctl_if.sv
// ============================================================================
// Module      : prt_dp_pm_hpd_ctl_if
// Description : Local bus towards the HPD peripheral plus the outgoing
//               event stream. master = controller, slave = peripheral/sink.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface prt_dp_pm_hpd_ctl_if;

  logic [1:0]  LB_ADR_OUT;
  logic        LB_WR_OUT;
  logic        LB_RD_OUT;
  logic [31:0] LB_DIN_OUT;
  logic [31:0] LB_DOUT_IN;
  logic        LB_VLD_IN;

  logic [1:0]  EVT_DAT_OUT;
  logic        EVT_VLD_OUT;
  logic        EVT_RDY_IN;

  modport master (
    output LB_ADR_OUT, LB_WR_OUT, LB_RD_OUT, LB_DIN_OUT,
    input  LB_DOUT_IN, LB_VLD_IN,
    output EVT_DAT_OUT, EVT_VLD_OUT,
    input  EVT_RDY_IN
  );

  modport slave (
    input  LB_ADR_OUT, LB_WR_OUT, LB_RD_OUT, LB_DIN_OUT,
    output LB_DOUT_IN, LB_VLD_IN,
    input  EVT_DAT_OUT, EVT_VLD_OUT,
    output EVT_RDY_IN
  );

endinterface

`default_nettype wire

// File: rtl/prt_dp_pm_hpd_evt_fifo.sv
// ============================================================================
// Module      : prt_dp_pm_hpd_evt_fifo
// Description : First-word-fall-through event FIFO with wrap-around
//               pointers and an occupancy count. A push into a full FIFO
//               is accepted only when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prt_dp_pm_hpd_evt_fifo #(
  parameter int P_DEPTH = 4,
  parameter int P_WIDTH = 2
) (
  input  wire               CLK_IN,
  input  wire               RST_IN,
  input  wire               push_in,
  input  wire [P_WIDTH-1:0] dat_in,
  input  wire               pop_in,
  output logic [P_WIDTH-1:0] dat_out,
  output logic              empty_out,
  output logic              full_out
);

  localparam int AW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(P_DEPTH);

  logic [P_WIDTH-1:0] mem_q [P_DEPTH];
  logic [P_WIDTH-1:0] mem_d [P_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        cnt_q, cnt_d;
  logic               wr_en, rd_en;

  assign empty_out = (cnt_q == '0);
  assign full_out  = (cnt_q == CNT_FULL);
  assign dat_out   = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and count
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rd_en    = pop_in & ~empty_out;
    wr_en    = push_in & (~full_out | rd_en);
    if (wr_en) begin
      mem_d[wr_ptr_q] = dat_in;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    cnt_d = cnt_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
  end

  // State registers
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      for (int i = 0; i < P_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/prt_dp_pm_hpd_ctl.sv
// ============================================================================
// Module      : prt_dp_pm_hpd_ctl
// Description : Services a DisplayPort HPD peripheral over a local bus:
//               starts it, reads status on interrupt, turns event bits into
//               a queued event stream, acknowledges observed events and
//               shuts the peripheral down when disabled.
//               Build option PRT_DP_PM_HPD_CTL_TIMEOUT_EN adds a read-valid
//               timeout that raises ERR_OUT; without it ERR_OUT is 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prt_dp_pm_hpd_ctl
  import prt_dp_pm_hpd_pkg::*;
#(
  parameter int P_FIFO_DEPTH = 4,
  parameter int P_TIMEOUT    = 16
) (
  input  wire                   CLK_IN,
  input  wire                   RST_IN,
  input  wire                   EN_IN,
  input  wire                   IRQ_IN,
  prt_dp_pm_hpd_ctl_if.master   bus,
  output logic                  HPD_LVL_OUT,
  output logic                  OVF_OUT,
  output logic                  ERR_OUT
);

  state_e      state_q, state_d;
  logic        lb_wr_q, lb_wr_d;
  logic        lb_rd_q, lb_rd_d;
  logic [1:0]  lb_adr_q, lb_adr_d;
  logic [31:0] lb_din_q, lb_din_d;
  logic        hpd_q, hpd_d;
  logic        ovf_q, ovf_d;
  logic [2:0]  evt_q, evt_d;    // event bits seen by the last status read
  logic [2:0]  pend_q, pend_d;  // event bits still to be queued
  logic        hold_q, hold_d;  // one-cycle IRQ holdoff after a clear

  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [1:0]  fifo_din;

`ifdef PRT_DP_PM_HPD_CTL_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(P_TIMEOUT - 1);
  logic        err_q, err_d;
  logic [7:0]  tmo_q, tmo_d;
  assign ERR_OUT = err_q;
`else
  logic        unused_tmo;
  assign unused_tmo = ^P_TIMEOUT;
  assign ERR_OUT    = 1'b0;
`endif

  logic unused_dout;
  assign unused_dout = ^{bus.LB_DOUT_IN[31:STAT_PULSE_BIT+1], bus.LB_DOUT_IN[STAT_CLR_BIT]};

  assign bus.LB_WR_OUT  = lb_wr_q;
  assign bus.LB_RD_OUT  = lb_rd_q;
  assign bus.LB_ADR_OUT = lb_adr_q;
  assign bus.LB_DIN_OUT = lb_din_q;
  assign HPD_LVL_OUT    = hpd_q;
  assign OVF_OUT        = ovf_q;

  assign bus.EVT_VLD_OUT = ~fifo_empty;
  assign fifo_pop        = bus.EVT_VLD_OUT & bus.EVT_RDY_IN;

  prt_dp_pm_hpd_evt_fifo #(
    .P_DEPTH (P_FIFO_DEPTH),
    .P_WIDTH (2)
  ) u_fifo (
    .CLK_IN    (CLK_IN),
    .RST_IN    (RST_IN),
    .push_in   (fifo_push),
    .dat_in    (fifo_din),
    .pop_in    (fifo_pop),
    .dat_out   (bus.EVT_DAT_OUT),
    .empty_out (fifo_empty),
    .full_out  (fifo_full)
  );

  // Next-state, registered bus outputs and event queuing
  always_comb begin
    state_d   = state_q;
    lb_wr_d   = 1'b0;
    lb_rd_d   = 1'b0;
    lb_adr_d  = '0;
    lb_din_d  = '0;
    hpd_d     = hpd_q;
    ovf_d     = ovf_q;
    evt_d     = evt_q;
    pend_d    = pend_q;
    hold_d    = hold_q;
    fifo_push = 1'b0;
    fifo_din  = '0;
`ifdef PRT_DP_PM_HPD_CTL_TIMEOUT_EN
    err_d     = err_q;
    tmo_d     = tmo_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (EN_IN) begin
          state_d = S_INIT;
          ovf_d   = 1'b0;
`ifdef PRT_DP_PM_HPD_CTL_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end

      S_INIT: begin
        lb_wr_d  = 1'b1;
        lb_adr_d = ADR_CTRL;
        lb_din_d = CTRL_START;
        hold_d   = 1'b0;
        state_d  = S_WAIT_IRQ;
      end

      S_WAIT_IRQ: begin
        // Disable wins; the holdoff lets the peripheral drop IRQ after a clear
        if (!EN_IN) begin
          hold_d  = 1'b0;
          state_d = S_STOP;
        end else if (hold_q) begin
          hold_d  = 1'b0;
        end else if (IRQ_IN) begin
          state_d = S_RD;
        end
      end

      S_RD: begin
        lb_rd_d  = 1'b1;
        lb_adr_d = ADR_STAT;
`ifdef PRT_DP_PM_HPD_CTL_TIMEOUT_EN
        tmo_d    = '0;
`endif
        state_d  = S_WAIT_VLD;
      end

      S_WAIT_VLD: begin
        if (bus.LB_VLD_IN) begin
          hpd_d   = bus.LB_DOUT_IN[STAT_HPD_BIT];
          evt_d   = bus.LB_DOUT_IN[STAT_PULSE_BIT:STAT_UNPLUG_BIT];
          pend_d  = bus.LB_DOUT_IN[STAT_PULSE_BIT:STAT_UNPLUG_BIT];
          state_d = (bus.LB_DOUT_IN[STAT_PULSE_BIT:STAT_UNPLUG_BIT] != 3'b000) ? S_PUSH : S_CLR;
        end
`ifdef PRT_DP_PM_HPD_CTL_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          hold_d  = 1'b1;
          state_d = S_WAIT_IRQ;
        end else begin
          tmo_d   = tmo_q + 8'd1;
        end
`endif
      end

      S_PUSH: begin
        // One event per cycle, unplug before plug before pulse
        fifo_push = 1'b1;
        if (pend_q[0]) begin
          fifo_din  = EVT_UNPLUG;
          pend_d[0] = 1'b0;
        end else if (pend_q[1]) begin
          fifo_din  = EVT_PLUG;
          pend_d[1] = 1'b0;
        end else begin
          fifo_din  = EVT_PULSE;
          pend_d[2] = 1'b0;
        end
        if (fifo_full && !fifo_pop) ovf_d = 1'b1;
        if (pend_d == 3'b000) state_d = S_CLR;
      end

      S_CLR: begin
        lb_wr_d  = 1'b1;
        lb_adr_d = ADR_STAT;
        lb_din_d = clr_word(evt_q);
        hold_d   = 1'b1;
        state_d  = S_WAIT_IRQ;
      end

      S_STOP: begin
        lb_wr_d  = 1'b1;
        lb_adr_d = ADR_CTRL;
        lb_din_d = '0;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      state_q  <= S_IDLE;
      lb_wr_q  <= 1'b0;
      lb_rd_q  <= 1'b0;
      lb_adr_q <= '0;
      lb_din_q <= '0;
      hpd_q    <= 1'b0;
      ovf_q    <= 1'b0;
      evt_q    <= '0;
      pend_q   <= '0;
      hold_q   <= 1'b0;
`ifdef PRT_DP_PM_HPD_CTL_TIMEOUT_EN
      err_q    <= 1'b0;
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      lb_wr_q  <= lb_wr_d;
      lb_rd_q  <= lb_rd_d;
      lb_adr_q <= lb_adr_d;
      lb_din_q <= lb_din_d;
      hpd_q    <= hpd_d;
      ovf_q    <= ovf_d;
      evt_q    <= evt_d;
      pend_q   <= pend_d;
      hold_q   <= hold_d;
`ifdef PRT_DP_PM_HPD_CTL_TIMEOUT_EN
      err_q    <= err_d;
      tmo_q    <= tmo_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prt_dp_pm_hpd_ctl.sv
// ============================================================================
// Module      : tb_prt_dp_pm_hpd_ctl
// Description : Scoreboard bench for prt_dp_pm_hpd_ctl with a small HPD
//               peripheral model. Expected bus writes and events are queued
//               by the stimulus and popped by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prt_dp_pm_hpd_ctl;

  typedef struct packed {
    logic [1:0]  adr;
    logic [31:0] dat;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic irq;
  logic hpd, ovf, err;

  int   n_chk = 0;
  int   n_err = 0;

  // Peripheral model controls (owned by the stimulus)
  logic [31:0] stat     = 32'd0;
  int          rsp_dly  = 1;
  logic        vld_en   = 1'b1;
  logic        irq_keep = 1'b0;
  logic        irq_drop = 1'b0;
  int          irq_gen  = 0;
  // Peripheral model state (owned by the model)
  int          irq_ack  = 0;
  int          rsp_cnt  = 0;

  wr_t         exp_wr[$];
  logic [1:0]  exp_evt[$];
  wr_t         mon_w;
  logic [1:0]  mon_e;

  prt_dp_pm_hpd_ctl_if bus ();

  assign irq = (irq_gen != irq_ack);

  prt_dp_pm_hpd_ctl #(
    .P_FIFO_DEPTH (4),
    .P_TIMEOUT    (16)
  ) dut (
    .CLK_IN      (clk),
    .RST_IN      (rst),
    .EN_IN       (en),
    .IRQ_IN      (irq),
    .bus         (bus),
    .HPD_LVL_OUT (hpd),
    .OVF_OUT     (ovf),
    .ERR_OUT     (err)
  );

  always #5 clk = ~clk;

  // HPD peripheral model: delayed read response, IRQ dropped by status clear
  always @(negedge clk) begin
    if (rst) begin
      bus.LB_VLD_IN  = 1'b0;
      bus.LB_DOUT_IN = 32'd0;
      rsp_cnt        = 0;
      irq_ack        = irq_gen;
    end else begin
      bus.LB_VLD_IN = 1'b0;
      if (rsp_cnt > 0) begin
        rsp_cnt = rsp_cnt - 1;
        if (rsp_cnt == 0) begin
          bus.LB_VLD_IN  = 1'b1;
          bus.LB_DOUT_IN = stat;
        end
      end
      if (bus.LB_RD_OUT && vld_en) rsp_cnt = rsp_dly;
      if ((bus.LB_WR_OUT && bus.LB_ADR_OUT == 2'd1 && !irq_keep) || irq_drop) irq_ack = irq_gen;
    end
  end

  // Monitor: compares every bus write and every accepted event against the queues
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.LB_WR_OUT && bus.LB_RD_OUT) begin
        n_chk++; n_err++;
        $display("FAIL bus_excl: wr=1 rd=1 together, required at most one");
      end
      if (bus.LB_WR_OUT) begin
        n_chk++;
        if (exp_wr.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_wr: adr=%0d dat=%08h, required no write", bus.LB_ADR_OUT, bus.LB_DIN_OUT);
        end else begin
          mon_w = exp_wr.pop_front();
          if (bus.LB_ADR_OUT !== mon_w.adr || bus.LB_DIN_OUT !== mon_w.dat) begin
            n_err++;
            $display("FAIL lb_write: got adr=%0d dat=%08h, required adr=%0d dat=%08h",
                     bus.LB_ADR_OUT, bus.LB_DIN_OUT, mon_w.adr, mon_w.dat);
          end
        end
      end
      if (bus.EVT_VLD_OUT && bus.EVT_RDY_IN) begin
        n_chk++;
        if (exp_evt.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_evt: code=%0d, required no event", bus.EVT_DAT_OUT);
        end else begin
          mon_e = exp_evt.pop_front();
          if (bus.EVT_DAT_OUT !== mon_e) begin
            n_err++;
            $display("FAIL evt_code: got %0d, required %0d", bus.EVT_DAT_OUT, mon_e);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic push_wr(input logic [1:0] a, input logic [31:0] d);
    wr_t w;
    w.adr = a;
    w.dat = d;
    exp_wr.push_back(w);
  endtask

  // Wait (bounded) until the monitor has consumed every expected item
  task automatic drain(input string nm, input int maxc);
    int c;
    c = 0;
    while ((exp_wr.size() != 0 || exp_evt.size() != 0) && c < maxc) begin
      @(posedge clk);
      c++;
    end
    n_chk++;
    if (exp_wr.size() != 0 || exp_evt.size() != 0) begin
      n_err++;
      $display("FAIL drain_%s: %0d writes and %0d events outstanding, required 0",
               nm, exp_wr.size(), exp_evt.size());
      exp_wr.delete();
      exp_evt.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic raise_irq(input logic [31:0] st);
    stat    = st;
    irq_gen = irq_gen + 1;
  endtask

  // Wait (bounded) at the sampling edge for a write to the given address
  task automatic wait_wr(input logic [1:0] a, output bit ok);
    int c;
    c  = 0;
    ok = 1'b0;
    while (!ok && c < 100) begin
      @(negedge clk);
      c++;
      if (bus.LB_WR_OUT && bus.LB_ADR_OUT == a) ok = 1'b1;
    end
  endtask

  task automatic wait_rd(output bit ok);
    int c;
    c  = 0;
    ok = 1'b0;
    while (!ok && c < 100) begin
      @(negedge clk);
      c++;
      if (bus.LB_RD_OUT) ok = 1'b1;
    end
  endtask

  initial begin
    int g;
    bit ok;
    bus.EVT_RDY_IN = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_wr",  {31'd0, bus.LB_WR_OUT}, 32'd0);
    chk("rst_rd",  {31'd0, bus.LB_RD_OUT}, 32'd0);
    chk("rst_adr_din", {bus.LB_DIN_OUT[29:0], bus.LB_ADR_OUT}, 32'd0);
    chk("rst_evt", {29'd0, bus.EVT_VLD_OUT, bus.EVT_DAT_OUT}, 32'd0);
    chk("rst_flags", {29'd0, hpd, ovf, err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Enable: start write within two cycles
    push_wr(2'd0, 32'h3);
    en = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("init_wr_2cyc", {31'd0, bus.LB_WR_OUT}, 32'd1);
    chk("init_evt_vld", {31'd0, bus.EVT_VLD_OUT}, 32'd0);
    drain("init", 20);

    // Status 0x0B: plug event, HPD high, clear 0x09
    exp_evt.push_back(2'd2);
    push_wr(2'd1, 32'h09);
    raise_irq(32'h0B);
    drain("st0b", 50);
    chk("hpd_0b", {31'd0, hpd}, 32'd1);

    // Status 0x15: unplug then pulse, clear 0x15, HPD low
    exp_evt.push_back(2'd1);
    exp_evt.push_back(2'd3);
    push_wr(2'd1, 32'h15);
    raise_irq(32'h15);
    drain("st15", 50);
    chk("hpd_15", {31'd0, hpd}, 32'd0);

    // Status 0x1F: all three events in order, clear 0x1D
    exp_evt.push_back(2'd1);
    exp_evt.push_back(2'd2);
    exp_evt.push_back(2'd3);
    push_wr(2'd1, 32'h1D);
    raise_irq(32'h1F);
    drain("st1f", 50);
    chk("hpd_1f", {31'd0, hpd}, 32'd1);

    // IRQ still high after the clear: re-read after exactly one idle cycle
    exp_evt.push_back(2'd2);
    exp_evt.push_back(2'd2);
    push_wr(2'd1, 32'h09);
    push_wr(2'd1, 32'h09);
    irq_keep = 1'b1;
    raise_irq(32'h08);
    wait_wr(2'd1, ok);
    chk("irq_keep_clr_seen", {31'd0, ok}, 32'd1);
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!bus.LB_RD_OUT && g < 20);
    chk("irq_rearm_gap", g, 32'd3);
    irq_keep = 1'b0;
    drain("irq_keep", 50);

    // Overflow: sink stalled, six plug events into a 4-deep FIFO
    bus.EVT_RDY_IN = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push_wr(2'd1, 32'h09);
      raise_irq(32'h08);
      drain("ovf_svc", 50);
      if (i == 3) chk("ovf_at_4", {31'd0, ovf}, 32'd0);
      if (i == 4) chk("ovf_at_5", {31'd0, ovf}, 32'd1);
    end
    chk("ovf_vld", {31'd0, bus.EVT_VLD_OUT}, 32'd1);
    for (int i = 0; i < 4; i++) exp_evt.push_back(2'd2);
    bus.EVT_RDY_IN = 1'b1;
    drain("ovf_pop", 20);
    chk("ovf_empty", {31'd0, bus.EVT_VLD_OUT}, 32'd0);
    chk("ovf_sticky", {31'd0, ovf}, 32'd1);

    // Disable during the read: service completes, then stop write
    rsp_dly = 6;
    exp_evt.push_back(2'd1);
    push_wr(2'd1, 32'h05);
    push_wr(2'd0, 32'h0);
    raise_irq(32'h04);
    wait_rd(ok);
    chk("endrop_rd_seen", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    en = 1'b0;
    drain("endrop", 50);
    rsp_dly = 1;
    repeat (10) @(posedge clk); #1;
    chk("endrop_no_rd", {31'd0, bus.LB_RD_OUT}, 32'd0);

    // Re-enable clears the sticky overflow
    push_wr(2'd0, 32'h3);
    en = 1'b1;
    drain("reinit", 20);
    chk("reinit_ovf", {31'd0, ovf}, 32'd0);
    chk("reinit_err", {31'd0, err}, 32'd0);

`ifdef PRT_DP_PM_HPD_CTL_TIMEOUT_EN
    // Read never answered: ERR after 16 cycles, no clear write
    vld_en = 1'b0;
    raise_irq(32'h08);
    wait_rd(ok);
    chk("tmo_rd_seen", {31'd0, ok}, 32'd1);
    g = 0;
    while (!err && g < 40) begin
      @(negedge clk);
      g++;
    end
    chk("tmo_cycles", g, 32'd16);
    @(posedge clk); #1;
    irq_drop = 1'b1;
    push_wr(2'd0, 32'h0);
    en = 1'b0;
    drain("tmo_stop", 100);
    chk("tmo_err_sticky", {31'd0, err}, 32'd1);
    vld_en   = 1'b1;
    irq_drop = 1'b0;
`else
    // Without the timeout option ERR stays low through a normal service
    exp_evt.push_back(2'd3);
    push_wr(2'd1, 32'h11);
    raise_irq(32'h10);
    drain("noerr", 50);
    chk("err_tied", {31'd0, err}, 32'd0);
    push_wr(2'd0, 32'h0);
    en = 1'b0;
    drain("final_stop", 30);
`endif

    repeat (5) @(posedge clk); #1;
    chk("end_wr_q", exp_wr.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // Global guard against a hung run
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
